altro_bus_slave: RTL and testbench



---
 rtl/altro_bus_slave.sv | 249 ++++++++++++++++++++++++
 tb/tb_altro_bus_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altro_bus_slave.sv
// rtl/altro_bus_slave.sv - ALTRO 40-bit bus TRU slave (CHRDO, register file); optional watchdog via ALTRO_BUS_SLAVE_TIMEOUT_EN
module altro_bus_slave #(
    parameter logic [3:0]  FEC_ADDR = 4'h0,
    parameter logic        BRANCH   = 1'b0,
    parameter logic [4:0]  CMD_RDO  = 5'h1A,
    parameter logic [4:0]  REG_BASE = 5'h10,
    parameter int          NREG     = 4,
    parameter logic [6:0]  LAST_CH  = 7'h7F,
    parameter logic [27:0] TRAILER  = 28'hAAA872A,
    parameter int          TMO_W    = 16
) (
    input  logic                rclk,
    input  logic                reset,
    input  logic                cstb,
    input  logic                write,
    input  logic [39:0]         bd,
    input  logic                trsf,
    output logic                ackn,
    output logic                ctrl_out,
    output logic                oeab,
    output logic                oeba,
    output logic [39:0]         bd_out,
    output logic                bd_oe,
    output logic                in_out,
    output logic                data_out_sign,
    output logic [6:0]          point_address,
    output logic [39:0]         last_40bit,
    output logic                readout_end,
    output logic [20*NREG-1:0]  cfg,
    output logic                err_tmo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DECODE,
        S_ACK,
        S_RELEASE,
        S_TURN,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state;
    logic [38:0] bd_q;
    logic        write_q;
    logic        trsf_q;
    logic        rdo_q;
    logic        branch_q;
    logic [19:0] regs [NREG];
    logic [19:0] rd_data;

    logic        hit;
    logic        bcast;
    logic        is_rdo;
    logic        is_reg;
    logic [5:0]  reg_off;
    logic [2:0]  reg_idx;
    logic        trsf_rise;
    logic        tmo_hit;

    // Address match: broadcast overrides the branch bit, bit 37 must be clear
    assign bcast     = bd_q[38];
    assign hit       = (bd_q[35:32] == FEC_ADDR) && !bd_q[37] && (bcast || (bd_q[36] == BRANCH));
    assign is_rdo    = (bd_q[24:20] == CMD_RDO);
    assign reg_off   = {1'b0, bd_q[24:20]} - {1'b0, REG_BASE};
    assign is_reg    = (bd_q[24:20] >= REG_BASE) && (reg_off < 6'(NREG));
    assign reg_idx   = reg_off[2:0];
    assign trsf_rise = !trsf_q && trsf;

    assign oeba          = ~oeab;
    assign data_out_sign = in_out;
    assign last_40bit    = {TRAILER, branch_q, 4'h0, point_address};

    // Flatten the register file onto cfg, reg0 in the LSBs
    for (genvar g = 0; g < NREG; g++) begin : g_cfg
        assign cfg[20*g +: 20] = regs[g];
    end

    // Register read mux
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (reg_idx == 3'(i)) begin
                rd_data = regs[i];
            end
        end
    end

`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);
    logic [TMO_W-1:0] tmo_cnt;

    // Handshake watchdog: held at zero outside ACK/DATA, counts every cycle while waiting there
    always_ff @(posedge rclk) begin
        if (reset || (state != S_ACK && state != S_DATA)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the cycle the counter is about to reach all-ones
    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    logic unused_tmo_w;

    // Without the watchdog ACK and DATA wait indefinitely; the width parameter has no effect
    assign tmo_hit      = 1'b0;
    assign err_tmo      = 1'b0;
    assign unused_tmo_w = (TMO_W != 0);
`endif

    // Transaction sequencer with registered bus-side outputs
    always_ff @(posedge rclk) begin
        if (reset) begin
            state         <= S_IDLE;
            bd_q          <= '0;
            write_q       <= 1'b0;
            trsf_q        <= 1'b0;
            rdo_q         <= 1'b0;
            branch_q      <= 1'b0;
            point_address <= '0;
            ackn          <= 1'b1;
            ctrl_out      <= 1'b1;
            oeab          <= 1'b1;
            bd_out        <= '0;
            bd_oe         <= 1'b0;
            in_out        <= 1'b0;
            readout_end   <= 1'b0;
`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
            err_tmo       <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            trsf_q      <= trsf;
            readout_end <= 1'b0;
`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
            err_tmo     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!cstb) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    bd_q    <= bd[38:0];
                    write_q <= write;
                    state   <= S_DECODE;
                end

                S_DECODE: begin
                    state <= S_IDLE;
                    rdo_q <= 1'b0;
                    if (hit) begin
                        if (is_rdo) begin
                            if (!write_q && !bcast) begin
                                point_address <= bd_q[31:25];
                                branch_q      <= bd_q[36];
                                rdo_q         <= 1'b1;
                                state         <= S_ACK;
                                ackn          <= 1'b0;
                                ctrl_out      <= 1'b0;
                            end
                        end else if (is_reg) begin
                            if (!write_q) begin
                                for (int i = 0; i < NREG; i++) begin
                                    if (reg_idx == 3'(i)) begin
                                        regs[i] <= bd_q[19:0];
                                    end
                                end
                                if (!bcast) begin
                                    state    <= S_ACK;
                                    ackn     <= 1'b0;
                                    ctrl_out <= 1'b0;
                                end
                            end else if (!bcast) begin
                                bd_out   <= {20'h0, rd_data};
                                bd_oe    <= 1'b1;
                                state    <= S_ACK;
                                ackn     <= 1'b0;
                                ctrl_out <= 1'b0;
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (cstb) begin
                        state    <= S_RELEASE;
                        ackn     <= 1'b1;
                        bd_oe    <= 1'b0;
                        ctrl_out <= 1'b1;
                    end else if (tmo_hit) begin
                        state    <= S_IDLE;
                        ackn     <= 1'b1;
                        bd_oe    <= 1'b0;
                        ctrl_out <= 1'b1;
`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
                        err_tmo  <= 1'b1;
`endif
                    end
                end

                S_RELEASE: begin
                    state <= rdo_q ? S_TURN : S_IDLE;
                end

                S_TURN: begin
                    state    <= S_DATA;
                    oeab     <= 1'b0;
                    in_out   <= 1'b1;
                    ctrl_out <= 1'b0;
                end

                S_DATA: begin
                    if (trsf_rise) begin
                        state       <= S_STOP;
                        oeab        <= 1'b1;
                        in_out      <= 1'b0;
                        ctrl_out    <= 1'b1;
                        readout_end <= (point_address == LAST_CH);
                    end else if (tmo_hit) begin
                        state    <= S_IDLE;
                        oeab     <= 1'b1;
                        in_out   <= 1'b0;
                        ctrl_out <= 1'b1;
`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
                        err_tmo  <= 1'b1;
`endif
                    end
                end

                S_STOP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_altro_bus_slave.sv
// tb/tb_altro_bus_slave.sv - self-checking bench for altro_bus_slave
module tb_altro_bus_slave;
    localparam int NREG = 4;

    logic               rclk = 1'b0;
    logic               reset;
    logic               cstb;
    logic               write;
    logic [39:0]        bd;
    logic               trsf;
    logic               ackn;
    logic               ctrl_out;
    logic               oeab;
    logic               oeba;
    logic [39:0]        bd_out;
    logic               bd_oe;
    logic               in_out;
    logic               data_out_sign;
    logic [6:0]         point_address;
    logic [39:0]        last_40bit;
    logic               readout_end;
    logic [20*NREG-1:0] cfg;
    logic               err_tmo;

    altro_bus_slave #(.NREG(NREG), .TMO_W(4)) dut (
        .rclk(rclk), .reset(reset), .cstb(cstb), .write(write), .bd(bd), .trsf(trsf),
        .ackn(ackn), .ctrl_out(ctrl_out), .oeab(oeab), .oeba(oeba), .bd_out(bd_out),
        .bd_oe(bd_oe), .in_out(in_out), .data_out_sign(data_out_sign),
        .point_address(point_address), .last_40bit(last_40bit), .readout_end(readout_end),
        .cfg(cfg), .err_tmo(err_tmo)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    logic [19:0] m_reg [NREG];
    logic [6:0]  m_point;
    logic        m_branch;

    typedef struct {
        logic [39:0] b;
        logic        w;
        logic        ack;
        logic        oe;
        logic [39:0] out;
        logic        rdo;
        logic        fin;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk_bd(input logic bc, input logic b37, input logic br,
                                          input logic [3:0] fec, input logic [2:0] chip,
                                          input logic [3:0] ch, input logic [4:0] instr,
                                          input logic [19:0] data);
        return {1'b0, bc, b37, br, fec, chip, ch, instr, data};
    endfunction

    // Transaction-level reference: what one bus transaction should do
    task automatic model_txn(input logic [39:0] b, input logic w, output logic ack, output logic oe,
                             output logic [39:0] out, output logic rdo, output logic fin);
        logic hit;
        int   instr;
        int   off;
        ack = 0; oe = 0; out = '0; rdo = 0; fin = 0;
        hit   = (b[35:32] == 4'h0) && !b[37] && (b[38] || (b[36] == 1'b0));
        instr = int'(b[24:20]);
        if (hit) begin
            if (instr == 'h1A) begin
                if (!w && !b[38]) begin
                    ack = 1; rdo = 1;
                    m_point  = b[31:25];
                    m_branch = b[36];
                    fin = (m_point == 7'h7F);
                end
            end else if (instr >= 'h10 && instr < 'h10 + NREG) begin
                off = instr - 'h10;
                if (!w) begin
                    m_reg[off] = b[19:0];
                    ack = !b[38];
                end else if (!b[38]) begin
                    ack = 1; oe = 1;
                    out = {20'h0, m_reg[off]};
                end
            end
        end
    endtask

    task automatic check_cfg(input string tag);
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("%s cfg%0d", tag, i), 64'(cfg[20*i +: 20]), 64'(m_reg[i]));
        end
    endtask

    task automatic run_txn(input logic [39:0] b, input logic w, input logic e_ack, input logic e_oe,
                           input logic [39:0] e_out, input logic e_rdo, input logic e_end,
                           input string tag);
        int          hold;
        int          low_cnt;
        int          ctrl_low;
        int          first_low;
        logic        oe_seen;
        logic [39:0] out_seen;
        int          dwell;
        hold = 4 + int'($urandom_range(0, 3));
        low_cnt = 0; ctrl_low = 0; first_low = -1; oe_seen = 0; out_seen = '0;
        @(negedge rclk);
        bd = b; write = w; cstb = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            @(negedge rclk);
            if (!ackn) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (!ctrl_out) ctrl_low++;
            if (bd_oe) begin
                oe_seen  = 1'b1;
                out_seen = bd_out;
            end
            if (k == 1 && e_ack) bd = {$urandom, $urandom};
            if (k == hold - 1) cstb = 1'b1;
        end
        check({tag, " ackn_cycles"}, 64'(low_cnt), e_ack ? 64'(hold - 2) : 64'd0);
        check({tag, " ctrl_cycles"}, 64'(ctrl_low), e_ack ? 64'(hold - 2) : 64'd0);
        if (e_ack) begin
            check({tag, " ackn_first"}, 64'(first_low), 64'd2);
            check({tag, " bd_oe_release"}, 64'(bd_oe), 64'd0);
        end
        check({tag, " bd_oe"}, 64'(oe_seen), 64'(e_oe));
        if (e_oe) check({tag, " bd_out"}, 64'(out_seen), 64'(e_out));
        if (e_rdo) begin
            @(negedge rclk);
            check({tag, " turn_oeab"}, 64'(oeab), 64'd1);
            @(negedge rclk);
            check({tag, " data_oe"}, 64'({oeab, oeba, in_out, data_out_sign, ctrl_out}), 64'b01110);
            dwell = int'($urandom_range(0, 3));
            repeat (dwell) @(negedge rclk);
            check({tag, " data_hold"}, 64'(oeab), 64'd0);
            trsf = 1'b1;
            @(negedge rclk);
            check({tag, " readout_end"}, 64'(readout_end), 64'(e_end));
            check({tag, " stop_oeab"}, 64'({oeab, in_out}), 64'b10);
            @(negedge rclk);
            trsf = 1'b0;
            check({tag, " readout_end_off"}, 64'(readout_end), 64'd0);
            check({tag, " point"}, 64'(point_address), 64'(m_point));
            check({tag, " last40"}, 64'(last_40bit), 64'({28'hAAA872A, m_branch, 4'h0, m_point}));
        end
        repeat (3) begin
            @(negedge rclk);
            check({tag, " idle"}, 64'({ackn, oeab, readout_end}), 64'b110);
        end
        check_cfg(tag);
    endtask

    initial begin
        logic        a_ack, a_oe, a_rdo, a_fin;
        logic [39:0] a_out;
        logic [39:0] rb;
        logic        rw;
        int          low_cnt;
        int          tmo_at;
        int          tmo_cnt;
        logic        seen_end;

        reset = 1'b1; cstb = 1'b1; write = 1'b1; trsf = 1'b0; bd = '0;
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_point = '0; m_branch = 1'b0;

        vecs[0]  = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h10,20'h12345), 1'b0, 1, 0, 40'h0, 0, 0};
        vecs[1]  = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h10,20'h00000), 1'b1, 1, 1, 40'h12345, 0, 0};
        vecs[2]  = '{mk_bd(1,0,1,4'h0,3'd0,4'd0,5'h11,20'hABCDE), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[3]  = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h11,20'h00000), 1'b1, 1, 1, 40'hABCDE, 0, 0};
        vecs[4]  = '{mk_bd(0,0,0,4'h1,3'd0,4'd0,5'h12,20'h55555), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[5]  = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h12,20'h00000), 1'b1, 1, 1, 40'h0, 0, 0};
        vecs[6]  = '{mk_bd(0,0,0,4'h0,3'd7,4'd15,5'h1A,20'h0), 1'b0, 1, 0, 40'h0, 1, 1};
        vecs[7]  = '{mk_bd(0,0,0,4'h0,3'd1,4'd2,5'h1A,20'h0), 1'b0, 1, 0, 40'h0, 1, 0};
        vecs[8]  = '{mk_bd(0,1,0,4'h0,3'd0,4'd0,5'h13,20'h77777), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[9]  = '{mk_bd(1,0,0,4'h0,3'd7,4'd15,5'h1A,20'h0), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[10] = '{mk_bd(1,0,0,4'h0,3'd0,4'd0,5'h10,20'h0), 1'b1, 0, 0, 40'h0, 0, 0};
        vecs[11] = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h05,20'h11111), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[12] = '{mk_bd(0,0,0,4'h0,3'd7,4'd15,5'h1A,20'h0), 1'b1, 0, 0, 40'h0, 0, 0};
        vecs[13] = '{mk_bd(0,0,1,4'h0,3'd0,4'd0,5'h13,20'h22222), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[14] = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h13,20'hFFFFF), 1'b0, 1, 0, 40'h0, 0, 0};
        vecs[15] = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h14,20'h33333), 1'b0, 0, 0, 40'h0, 0, 0};
        vecs[16] = '{mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h13,20'h00000), 1'b1, 1, 1, 40'hFFFFF, 0, 0};

        repeat (3) @(negedge rclk);
        reset = 1'b0;
        check("reset outputs",
              64'({ackn, ctrl_out, oeab, oeba, bd_oe, in_out, data_out_sign, readout_end, err_tmo}),
              64'b111000000);
        check("reset point", 64'(point_address), 64'd0);
        check("reset bd_out", 64'(bd_out), 64'd0);
        check("reset last40", 64'(last_40bit), 64'h00AAA872A000);
        check_cfg("reset");

        for (int i = 0; i < 17; i++) begin
            model_txn(vecs[i].b, vecs[i].w, a_ack, a_oe, a_out, a_rdo, a_fin);
            run_txn(vecs[i].b, vecs[i].w, vecs[i].ack, vecs[i].oe, vecs[i].out,
                    vecs[i].rdo, vecs[i].fin, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 150; n++) begin
            logic [4:0] instr;
            logic [6:0] cc;
            int         r;
            r = int'($urandom_range(0, 9));
            if (r < 3)      instr = 5'h1A;
            else if (r < 9) instr = 5'h10 + 5'($urandom_range(0, 4));
            else            instr = 5'($urandom);
            cc = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom);
            rb = mk_bd($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0,
                       ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
                       cc[6:4], cc[3:0], instr, 20'($urandom));
            rw = 1'($urandom);
            model_txn(rb, rw, a_ack, a_oe, a_out, a_rdo, a_fin);
            run_txn(rb, rw, a_ack, a_oe, a_out, a_rdo, a_fin, $sformatf("rnd%0d", n));
        end

        seen_end = 1'b0;
        trsf = 1'b1;
        repeat (2) begin
            @(negedge rclk);
            if (readout_end) seen_end = 1'b1;
        end
        trsf = 1'b0;
        @(negedge rclk);
        check("trsf_idle no readout_end", 64'(seen_end), 64'd0);
        check("trsf_idle oeab", 64'({ackn, oeab}), 64'b11);

        @(negedge rclk);
        bd = mk_bd(0,0,0,4'h0,3'd2,4'd3,5'h1A,20'h0); write = 1'b0; cstb = 1'b0;
        repeat (4) @(negedge rclk);
        cstb = 1'b1;
        repeat (3) @(negedge rclk);
        check("seq_data entered", 64'({oeab, in_out}), 64'b01);
        cstb = 1'b0;
        repeat (2) @(negedge rclk);
        cstb = 1'b1;
        check("seq_data cstb ignored", 64'({ackn, oeab, in_out}), 64'b101);
`ifndef ALTRO_BUS_SLAVE_TIMEOUT_EN
        tmo_cnt = 0;
        repeat (20) begin
            @(negedge rclk);
            if (err_tmo) tmo_cnt++;
        end
        check("seq_data no timeout", 64'({oeab, in_out}), 64'b01);
        check("seq_data err_tmo", 64'(tmo_cnt), 64'd0);
`endif
        reset = 1'b1;
        @(negedge rclk);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_point = '0; m_branch = 1'b0;
        check("seq_reset outputs", 64'({ackn, ctrl_out, oeab, oeba, in_out, bd_oe}), 64'b111000);
        check("seq_reset point", 64'(point_address), 64'd0);
        check_cfg("seq_reset");
        seen_end = 1'b0;
        trsf = 1'b1;
        repeat (3) begin
            @(negedge rclk);
            if (readout_end) seen_end = 1'b1;
        end
        trsf = 1'b0;
        check("seq_reset no readout_end", 64'(seen_end), 64'd0);

        @(negedge rclk);
        bd = mk_bd(0,0,0,4'h0,3'd0,4'd0,5'h12,20'h0BEEF); write = 1'b0; cstb = 1'b0;
        m_reg[2] = 20'h0BEEF;
        low_cnt = 0; tmo_at = -1; tmo_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge rclk);
            if (!ackn) low_cnt++;
            if (err_tmo) begin
                tmo_cnt++;
                if (tmo_at < 0) tmo_at = k;
                cstb = 1'b1;
            end
        end
        cstb = 1'b1;
        repeat (4) @(negedge rclk);
`ifdef ALTRO_BUS_SLAVE_TIMEOUT_EN
        check("long_ack err_tmo cycle", 64'(tmo_at), 64'd17);
        check("long_ack err_tmo pulses", 64'(tmo_cnt), 64'd1);
        check("long_ack ackn cycles", 64'(low_cnt), 64'd15);
`else
        check("long_ack err_tmo pulses", 64'(tmo_cnt), 64'd0);
        check("long_ack ackn cycles", 64'(low_cnt), 64'd28);
`endif
        check("long_ack released", 64'({ackn, bd_oe, oeab}), 64'b101);
        check_cfg("long_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
